// File: rtl/memory_arbiter.sv
// Two-port (instruction / data) arbiter in front of a single-port ram, with a grant timeout.
// Optional round-robin arbitration between the ports is enabled by defining MEM_ARB_FAIR_EN.

package memory_arbiter_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          access;
    logic          d_req;
    logic          grant_d;
    logic          grant_i;
    logic          granted_req;
`ifdef MEM_ARB_FAIR_EN
    logic          last_i;
`endif

    // Ram mux and per-port wait; a pending reset already hides the grant from the ram.
    always_comb begin
        access      = (ramstate == ACCESS);
        d_req       = dREN | dWEN;
        grant_d     = (state == GRANT_D) & ~RST;
        grant_i     = (state == GRANT_I) & ~RST;
        granted_req = (state == GRANT_D) ? d_req : iREN;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = 32'd0;
        ramstore    = 32'd0;
        if (grant_d) begin
            ramREN   = dREN & ~dWEN;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
        end else if (grant_i) begin
            ramREN   = 1'b1;
            ramWEN   = 1'b0;
            ramaddr  = iaddr;
            ramstore = 32'd0;
        end else begin
            ramREN   = 1'b0;
            ramWEN   = 1'b0;
            ramaddr  = 32'd0;
            ramstore = 32'd0;
        end
        iwait = iREN & ~(grant_i & access);
        dwait = d_req & ~(grant_d & access);
        iload = ramload;
        dload = ramload;
    end

    // Grant FSM with timeout counter and sticky error flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
            last_i <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
`ifdef MEM_ARB_FAIR_EN
                    if (d_req && iREN) begin
                        state <= last_i ? GRANT_D : GRANT_I;
                    end else if (d_req) begin
                        state <= GRANT_D;
                    end else if (iREN) begin
                        state <= GRANT_I;
                    end else begin
                        state <= IDLE;
                    end
`else
                    if (d_req) begin
                        state <= GRANT_D;
                    end else if (iREN) begin
                        state <= GRANT_I;
                    end else begin
                        state <= IDLE;
                    end
`endif
                end
                GRANT_D, GRANT_I: begin
                    if (access) begin
                        state <= IDLE;
                        cnt   <= '0;
`ifdef MEM_ARB_FAIR_EN
                        last_i <= (state == GRANT_I);
`endif
                    end else if (!granted_req) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Abort without completing; the requester keeps waiting and retries.
                        err   <= 1'b1;
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
